// File: rtl/idli_mem_sched_m.sv
// idli_mem_sched_m: memory-slot scheduler for a nibble-serial core.
// A free-running 2-bit slice counter frames 4-cycle words. Each word is either an
// address word (ADDR: target address streamed LSN first on o_sch_slice) or a data
// word (DATA: instruction fetch, load or store). Fetch streams sequential words until a
// branch redirect or a load/store request interrupts it at a word boundary.
// Optional feature macro: IDLI_SCHED_FAIR_EN. When it is defined, at least one fetch
// word completes between two load/store grants. When it is undefined, a request still
// high at the end of a load/store data word is granted again back-to-back.
// Request handshake: a requester wanting a single access drops i_sch_ls_req within the
// cycle that shows o_sch_ls_done. A request still high at that boundary counts as a new one.
module idli_mem_sched_m (
    input  logic        i_sch_gck,
    input  logic        i_sch_rst,
    output logic [1:0]  o_sch_ctr,
    input  logic        i_sch_br_vld,
    input  logic [15:0] i_sch_br_addr,
    input  logic        i_sch_ls_req,
    input  logic        i_sch_ls_wr,
    input  logic [15:0] i_sch_ls_addr,
    input  logic [3:0]  i_sch_ls_wslice,
    output logic        o_sch_ls_done,
    output logic        o_sch_redirect,
    output logic        o_sch_wr_en,
    output logic [3:0]  o_sch_slice,
    output logic        o_sch_fetch_vld
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

    logic [1:0]  ctr_q, ctr_d;
    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] addr_q, addr_d;       // address streamed during the current ADDR word
    logic [15:0] pc_q, pc_d;           // address of the fetch word in flight / next to fetch
    logic        br_pend_q, br_pend_d;
    logic [15:0] br_addr_q, br_addr_d;

    logic        word_end;
    logic        br_now;
    logic [15:0] br_tgt;
    logic [3:0]  addr_nib [4];

    // Split the transaction address into its four nibbles, index 0 = least significant.
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        assign addr_nib[gi] = addr_q[4*gi +: 4];
    end

    assign word_end = (ctr_q == 2'd3);
    // A pulse arriving on a deciding boundary is used directly instead of via the latch.
    assign br_now   = i_sch_br_vld | br_pend_q;
    assign br_tgt   = i_sch_br_vld ? i_sch_br_addr : br_addr_q;

    // Next-state logic: counter, branch latch, FSM and address/PC bookkeeping.
    always_comb begin
        ctr_d     = ctr_q + 2'd1;
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        br_pend_d = br_pend_q;
        br_addr_d = br_addr_q;

        // Latch every branch pulse; a later one overwrites the earlier target.
        if (i_sch_br_vld) begin
            br_pend_d = 1'b1;
            br_addr_d = i_sch_br_addr;
        end

        if (word_end) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ADDR;
                    op_d    = OP_FETCH;
                    if (br_now) begin
                        addr_d    = br_tgt;
                        pc_d      = br_tgt;
                        br_pend_d = 1'b0;
                    end else begin
                        addr_d = pc_q;
                    end
                end
                ST_ADDR: begin
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (op_q == OP_FETCH) begin
                        if (br_now) begin
                            // Squashed word: PC is replaced by the branch target.
                            state_d   = ST_ADDR;
                            addr_d    = br_tgt;
                            pc_d      = br_tgt;
                            br_pend_d = 1'b0;
                        end else begin
                            pc_d = pc_q + 16'd1;
                            if (i_sch_ls_req) begin
                                state_d = ST_ADDR;
                                op_d    = i_sch_ls_wr ? OP_STORE : OP_LOAD;
                                addr_d  = i_sch_ls_addr;
                            end
                        end
                    end else begin
                        state_d = ST_ADDR;
                        if (br_now) begin
                            op_d      = OP_FETCH;
                            addr_d    = br_tgt;
                            pc_d      = br_tgt;
                            br_pend_d = 1'b0;
`ifdef IDLI_SCHED_FAIR_EN
                        end else begin
                            // A fetch word must complete before the next grant.
                            op_d   = OP_FETCH;
                            addr_d = pc_q;
                        end
`else
                        end else if (i_sch_ls_req) begin
                            op_d   = i_sch_ls_wr ? OP_STORE : OP_LOAD;
                            addr_d = i_sch_ls_addr;
                        end else begin
                            op_d   = OP_FETCH;
                            addr_d = pc_q;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    op_d    = OP_FETCH;
                end
            endcase
        end
    end

    // State registers; reset takes effect immediately, even mid-transaction.
    always_ff @(posedge i_sch_gck or posedge i_sch_rst) begin
        if (i_sch_rst) begin
            ctr_q     <= 2'd0;
            state_q   <= ST_IDLE;
            op_q      <= OP_FETCH;
            addr_q    <= 16'h0000;
            pc_q      <= 16'h0000;
            br_pend_q <= 1'b0;
            br_addr_q <= 16'h0000;
        end else begin
            ctr_q     <= ctr_d;
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            br_pend_q <= br_pend_d;
            br_addr_q <= br_addr_d;
        end
    end

    // Output decode from the registered state; all zero in IDLE.
    always_comb begin
        o_sch_redirect  = (state_q == ST_ADDR);
        o_sch_wr_en     = (state_q != ST_IDLE) && (op_q == OP_STORE);
        o_sch_ls_done   = (state_q == ST_DATA) && (op_q != OP_FETCH) && word_end;
        o_sch_fetch_vld = (state_q == ST_DATA) && (op_q == OP_FETCH) && !br_now;
        o_sch_slice     = 4'h0;
        if (state_q == ST_ADDR) begin
            o_sch_slice = addr_nib[ctr_q];
        end else if ((state_q == ST_DATA) && (op_q == OP_STORE)) begin
            o_sch_slice = i_sch_ls_wslice;
        end
    end

    assign o_sch_ctr = ctr_q;

endmodule

// File: tb/tb_idli_mem_sched_m.sv
// tb_idli_mem_sched_m: directed, cycle-by-cycle check of idli_mem_sched_m.
// Honors IDLI_SCHED_FAIR_EN for the held-request scenario.
module tb_idli_mem_sched_m;

    logic        clk;
    logic        rst;
    logic [1:0]  ctr;
    logic        br_vld;
    logic [15:0] br_addr;
    logic        ls_req;
    logic        ls_wr;
    logic [15:0] ls_addr;
    logic [3:0]  wslice;
    logic        ls_done;
    logic        redirect;
    logic        wr_en;
    logic [3:0]  slice;
    logic        fetch_vld;

    // Stimulus staged for the next cycle; applied at the following falling edge.
    logic        nx_rst;
    logic        nx_br_vld;
    logic [15:0] nx_br_addr;
    logic        nx_ls_req;
    logic        nx_ls_wr;
    logic [15:0] nx_ls_addr;
    logic [3:0]  nx_wslice;

    int n_chk;
    int n_fail;
    int cyc;
    logic [15:0] last_pc;

    logic [9:0] obs;
    assign obs = {ctr, redirect, wr_en, slice, fetch_vld, ls_done};

    idli_mem_sched_m dut (
        .i_sch_gck       (clk),
        .i_sch_rst       (rst),
        .o_sch_ctr       (ctr),
        .i_sch_br_vld    (br_vld),
        .i_sch_br_addr   (br_addr),
        .i_sch_ls_req    (ls_req),
        .i_sch_ls_wr     (ls_wr),
        .i_sch_ls_addr   (ls_addr),
        .i_sch_ls_wslice (wslice),
        .o_sch_ls_done   (ls_done),
        .o_sch_redirect  (redirect),
        .o_sch_wr_en     (wr_en),
        .o_sch_slice     (slice),
        .o_sch_fetch_vld (fetch_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input logic [1:0] c, input logic r, input logic w,
                                      input logic [3:0] s, input logic f, input logic d);
        return {c, r, w, s, f, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (ctr,redir,wr,slice,fvld,done)", tag, got, want);
        end
    endtask

    // One clock cycle: apply staged inputs at the falling edge, then check outputs.
    task automatic cycle(input string tag, input logic r, input logic w,
                         input logic [3:0] s, input logic f, input logic d);
        logic [1:0] c;
        @(negedge clk);
        rst     = nx_rst;
        br_vld  = nx_br_vld;
        br_addr = nx_br_addr;
        ls_req  = nx_ls_req;
        ls_wr   = nx_ls_wr;
        ls_addr = nx_ls_addr;
        wslice  = nx_wslice;
        #1;
        c = cyc[1:0];
        chk($sformatf("%s@%0d", tag, cyc), {22'd0, obs}, {22'd0, pk(c, r, w, s, f, d)});
        $display("cyc %0d %s: ctr=%0d redir=%b wr=%b slice=%h fvld=%b done=%b",
                 cyc, tag, ctr, redirect, wr_en, slice, fetch_vld, ls_done);
        cyc++;
    endtask

    task automatic idle_word(input string tag);
        for (int i = 0; i < 4; i++) cycle(tag, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic addr_word(input string tag, input logic [15:0] a, input logic w);
        for (int i = 0; i < 4; i++) cycle(tag, 1'b1, w, a[4*i +: 4], 1'b0, 1'b0);
    endtask

    task automatic fetch_word(input string tag);
        for (int i = 0; i < 4; i++) cycle(tag, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    // Load/store data word; when drop is set the request falls in the done cycle.
    task automatic ls_data_word(input string tag, input logic w, input logic [15:0] data,
                                input logic drop);
        for (int i = 0; i < 4; i++) begin
            if (w) nx_wslice = data[4*i +: 4];
            cycle(tag, 1'b0, w, w ? data[4*i +: 4] : 4'h0, 1'b0, i == 3);
        end
        nx_wslice = 4'hA;
        if (drop) begin
            ls_req    = 1'b0;
            nx_ls_req = 1'b0;
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; br_vld = 1'b0; br_addr = 16'h0; ls_req = 1'b0; ls_wr = 1'b0;
        ls_addr = 16'h0; wslice = 4'hF;
        nx_rst = 1'b1; nx_br_vld = 1'b0; nx_br_addr = 16'h0; nx_ls_req = 1'b0;
        nx_ls_wr = 1'b0; nx_ls_addr = 16'h0; nx_wslice = 4'hA;

        // Reset state: everything zero.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", {22'd0, obs}, 32'd0);

        // Release, no requests: idle word, redirect to PC 0, then streaming fetch.
        nx_rst = 1'b0;
        cyc = 0;
        idle_word("idle");
        addr_word("a_pc0", 16'h0000, 1'b0);
        fetch_word("f_pc0");
        fetch_word("f_pc1");

        // Load at 0x1234 requested during a fetch word.
        nx_ls_req = 1'b1; nx_ls_wr = 1'b0; nx_ls_addr = 16'h1234;
        fetch_word("f_pc2");
        addr_word("a_ld1234", 16'h1234, 1'b0);
        ls_data_word("d_ld1234", 1'b0, 16'h0, 1'b1);
        addr_word("a_pc3", 16'h0003, 1'b0);

        // Store 0xBEEF at 0x0010.
        nx_ls_req = 1'b1; nx_ls_wr = 1'b1; nx_ls_addr = 16'h0010;
        fetch_word("f_pc3");
        nx_ls_wr = 1'b0;
        ls_wr = 1'b1;
        addr_word("a_st0010", 16'h0010, 1'b1);
        ls_data_word("d_stbeef", 1'b1, 16'hBEEF, 1'b1);
        addr_word("a_pc4", 16'h0004, 1'b0);

        // Branch to 0xFFFF at ctr 1 together with a load request: branch wins.
        cycle("f_pc4", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        nx_br_vld = 1'b1; nx_br_addr = 16'hFFFF;
        nx_ls_req = 1'b1; nx_ls_wr = 1'b0; nx_ls_addr = 16'h00A5;
        cycle("sq_br", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        nx_br_vld = 1'b0;
        cycle("sq_pend", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle("sq_pend", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        addr_word("a_brffff", 16'hFFFF, 1'b0);
        fetch_word("f_ffff");
        addr_word("a_ld00a5", 16'h00A5, 1'b0);
        ls_data_word("d_ld00a5", 1'b0, 16'h0, 1'b1);
        addr_word("a_pcwrap", 16'h0000, 1'b0);

        // Load request held continuously.
        nx_ls_req = 1'b1; nx_ls_wr = 1'b0; nx_ls_addr = 16'h0003;
        fetch_word("f_pc0b");
        addr_word("a_ld3a", 16'h0003, 1'b0);
        ls_data_word("d_ld3a", 1'b0, 16'h0, 1'b0);
`ifdef IDLI_SCHED_FAIR_EN
        addr_word("a_fair_pc1", 16'h0001, 1'b0);
        fetch_word("f_fair_pc1");
        addr_word("a_ld3b", 16'h0003, 1'b0);
        ls_data_word("d_ld3b", 1'b0, 16'h0, 1'b1);
        last_pc = 16'h0002;
`else
        addr_word("a_ld3b", 16'h0003, 1'b0);
        ls_data_word("d_ld3b", 1'b0, 16'h0, 1'b1);
        last_pc = 16'h0001;
`endif

        // Reset asserted mid-ADDR at ctr 2.
        cycle("a_pre_rst", 1'b1, 1'b0, last_pc[3:0], 1'b0, 1'b0);
        cycle("a_pre_rst", 1'b1, 1'b0, last_pc[7:4], 1'b0, 1'b0);
        cycle("a_pre_rst", 1'b1, 1'b0, last_pc[11:8], 1'b0, 1'b0);
        #2;
        rst = 1'b1; nx_rst = 1'b1;
        #1;
        chk("rst_mid", {22'd0, obs}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_hold", {22'd0, obs}, 32'd0);

        // Restart from PC 0.
        nx_rst = 1'b0;
        cyc = 0;
        idle_word("idle2");
        addr_word("a_restart", 16'h0000, 1'b0);
        fetch_word("f_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
